// File: rtl/mio_axis_arb.sv
// Round-robin AXI4-Stream packet arbiter: NUM_SRC slave ports share one registered master port.
// Optional MIO_AXIS_ARB_SRC_TAG_EN: m_tid carries the granted source index instead of s_tid.
module mio_axis_arb #(
  parameter int NUM_SRC     = 4,
  parameter int TDATA_SIZE  = 4,
  parameter int TID_WIDTH   = 8,
  parameter int TDEST_WIDTH = 4,
  parameter int TUSER_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_SRC-1:0]                s_tvalid,
  output logic [NUM_SRC-1:0]                s_tready,
  input  logic [NUM_SRC*TDATA_SIZE*8-1:0]   s_tdata,
  input  logic [NUM_SRC*TDATA_SIZE-1:0]     s_tstrb,
  input  logic [NUM_SRC*TDATA_SIZE-1:0]     s_tkeep,
  input  logic [NUM_SRC-1:0]                s_tlast,
  input  logic [NUM_SRC*TID_WIDTH-1:0]      s_tid,
  input  logic [NUM_SRC*TDEST_WIDTH-1:0]    s_tdest,
  input  logic [NUM_SRC*TUSER_WIDTH-1:0]    s_tuser,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic [TDATA_SIZE*8-1:0]           m_tdata,
  output logic [TDATA_SIZE-1:0]             m_tstrb,
  output logic [TDATA_SIZE-1:0]             m_tkeep,
  output logic                              m_tlast,
  output logic [TID_WIDTH-1:0]              m_tid,
  output logic [TDEST_WIDTH-1:0]            m_tdest,
  output logic [TUSER_WIDTH-1:0]            m_tuser,
  output logic [NUM_SRC-1:0]                grant,
  output logic                              busy
);

  localparam int DW = TDATA_SIZE * 8;
  localparam int SW = TDATA_SIZE;
  localparam int IW = $clog2(NUM_SRC);

  // Handshake: a beat transfers on a rising clk edge where tvalid and tready are both high;
  // tvalid never waits on tready, and s_tready is combinational from grant and the output slot.
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [NUM_SRC-1:0]     grant_q, grant_d;
  logic [IW-1:0]          last_q, last_d;
  logic                   m_tvalid_q, m_tvalid_d;
  logic [DW-1:0]          m_tdata_q, m_tdata_d;
  logic [SW-1:0]          m_tstrb_q, m_tstrb_d;
  logic [SW-1:0]          m_tkeep_q, m_tkeep_d;
  logic                   m_tlast_q, m_tlast_d;
  logic [TID_WIDTH-1:0]   m_tid_q, m_tid_d;
  logic [TDEST_WIDTH-1:0] m_tdest_q, m_tdest_d;
  logic [TUSER_WIDTH-1:0] m_tuser_q, m_tuser_d;

  logic [IW-1:0]          gidx;
  logic [IW-1:0]          pick_idx;
  logic                   pick_hit;
  int                     best_d;
  logic                   accept;

`ifdef MIO_AXIS_ARB_SRC_TAG_EN
  logic unused_tid;
  assign unused_tid = ^s_tid;
`endif

  // Distance of each requester from last_q+1 (mod NUM_SRC); the nearest one wins.
  always_comb begin
    pick_hit = 1'b0;
    pick_idx = '0;
    best_d   = NUM_SRC;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (s_tvalid[i] && ((i + NUM_SRC - 1 - int'(last_q)) % NUM_SRC) < best_d) begin
        best_d   = (i + NUM_SRC - 1 - int'(last_q)) % NUM_SRC;
        pick_idx = IW'(i);
        pick_hit = 1'b1;
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) gidx = IW'(i);
    end
  end

  always_comb begin
    s_tready   = (state_q == LOCKED) ? (grant_q & {NUM_SRC{~m_tvalid_q | m_tready}}) : '0;
    accept     = |(s_tvalid & s_tready);
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tstrb_d  = m_tstrb_q;
    m_tkeep_d  = m_tkeep_q;
    m_tlast_d  = m_tlast_q;
    m_tid_d    = m_tid_q;
    m_tdest_d  = m_tdest_q;
    m_tuser_d  = m_tuser_q;

    if (accept) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = s_tdata[int'(gidx)*DW +: DW];
      m_tstrb_d  = s_tstrb[int'(gidx)*SW +: SW];
      m_tkeep_d  = s_tkeep[int'(gidx)*SW +: SW];
      m_tlast_d  = s_tlast[gidx];
`ifdef MIO_AXIS_ARB_SRC_TAG_EN
      m_tid_d    = TID_WIDTH'(gidx);
`else
      m_tid_d    = s_tid[int'(gidx)*TID_WIDTH +: TID_WIDTH];
`endif
      m_tdest_d  = s_tdest[int'(gidx)*TDEST_WIDTH +: TDEST_WIDTH];
      m_tuser_d  = s_tuser[int'(gidx)*TUSER_WIDTH +: TUSER_WIDTH];
    end else if (m_tready) begin
      m_tvalid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (pick_hit) begin
          grant_d = NUM_SRC'(1) << pick_idx;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && s_tlast[gidx]) begin
          last_d  = gidx;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= IW'(NUM_SRC - 1);
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tstrb_q  <= '0;
      m_tkeep_q  <= '0;
      m_tlast_q  <= 1'b0;
      m_tid_q    <= '0;
      m_tdest_q  <= '0;
      m_tuser_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tstrb_q  <= m_tstrb_d;
      m_tkeep_q  <= m_tkeep_d;
      m_tlast_q  <= m_tlast_d;
      m_tid_q    <= m_tid_d;
      m_tdest_q  <= m_tdest_d;
      m_tuser_q  <= m_tuser_d;
    end
  end

  // busy doubles as the observable FSM state (high = LOCKED).
  assign busy     = (state_q == LOCKED);
  assign grant    = grant_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tdata  = m_tdata_q;
  assign m_tstrb  = m_tstrb_q;
  assign m_tkeep  = m_tkeep_q;
  assign m_tlast  = m_tlast_q;
  assign m_tid    = m_tid_q;
  assign m_tdest  = m_tdest_q;
  assign m_tuser  = m_tuser_q;

endmodule

// File: tb/tb_mio_axis_arb.sv
// Bench for mio_axis_arb: queued per-source packet drivers, a round-robin packet-level
// reference model checked every cycle, and a beat scoreboard from slave side to master side.
module tb_mio_axis_arb;

  localparam int N = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic [7:0]  tid;
    logic [3:0]  dest;
    logic [7:0]  user;
  } beat_t;

  typedef struct {
    beat_t b;
    int    gap;
  } item_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] s_tvalid, s_tready, s_tlast;
  logic [N*32-1:0] s_tdata;
  logic [N*4-1:0]  s_tstrb, s_tkeep, s_tdest;
  logic [N*8-1:0]  s_tid, s_tuser;
  logic         m_tvalid, m_tready, m_tlast;
  logic [31:0]  m_tdata;
  logic [3:0]   m_tstrb, m_tkeep, m_tdest;
  logic [7:0]   m_tid, m_tuser;
  logic [N-1:0] grant;
  logic         busy;

  mio_axis_arb #(.NUM_SRC(N), .TDATA_SIZE(4), .TID_WIDTH(8), .TDEST_WIDTH(4), .TUSER_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tstrb(s_tstrb),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tstrb(m_tstrb),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
    .grant(grant), .busy(busy)
  );

  // ---------------- clock ----------------
  initial forever #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver state ----------------
  item_t       pend_q[N][$];
  beat_t       cur_b[N];
  logic [N-1:0] cur_valid = '0;
  logic [N-1:0] acc = '0;
  int          gap_left[N];
  int          rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

  task automatic push_beat(input int s, input beat_t b, input int gap);
    item_t it;
    it.b   = b;
    it.gap = gap;
    pend_q[s].push_back(it);
  endtask

  // tdata = {source, packet, beat, random} so every beat is traceable to its origin.
  task automatic push_pkt(input int s, input int nb, input int pkt, input int gap0,
                          input int mid_at, input int mid_gap, input int tid);
    beat_t b;
    for (int k = 0; k < nb; k++) begin
      b.data = {8'(s), 8'(pkt), 8'(k), 8'($urandom_range(0, 255))};
      b.strb = 4'($urandom_range(0, 15));
      b.keep = 4'($urandom_range(0, 15));
      b.last = (k == nb - 1);
      b.tid  = (tid < 0) ? 8'($urandom_range(0, 255)) : 8'(tid);
      b.dest = 4'($urandom_range(0, 15));
      b.user = 8'($urandom_range(0, 255));
      push_beat(s, b, (k == 0) ? gap0 : ((k == mid_at) ? mid_gap : 0));
    end
  endtask

  initial begin
    for (int s = 0; s < N; s++) gap_left[s] = -1;
    s_tvalid = '0; s_tdata = '0; s_tstrb = '0; s_tkeep = '0; s_tlast = '0;
    s_tid = '0; s_tdest = '0; s_tuser = '0; m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int s = 0; s < N; s++) begin
        if (reset) begin
          pend_q[s].delete();
          cur_valid[s] = 1'b0;
          gap_left[s]  = -1;
        end else begin
          if (acc[s]) cur_valid[s] = 1'b0;
          if (!cur_valid[s] && pend_q[s].size() > 0) begin
            if (gap_left[s] < 0) gap_left[s] = pend_q[s][0].gap;
            if (gap_left[s] > 0) gap_left[s]--;
            else begin
              cur_b[s]     = pend_q[s].pop_front().b;
              cur_valid[s] = 1'b1;
              gap_left[s]  = -1;
            end
          end
        end
        s_tvalid[s]          = cur_valid[s];
        s_tdata[s*32 +: 32]  = cur_b[s].data;
        s_tstrb[s*4 +: 4]    = cur_b[s].strb;
        s_tkeep[s*4 +: 4]    = cur_b[s].keep;
        s_tlast[s]           = cur_b[s].last;
        s_tid[s*8 +: 8]      = cur_b[s].tid;
        s_tdest[s*4 +: 4]    = cur_b[s].dest;
        s_tuser[s*8 +: 8]    = cur_b[s].user;
      end
      m_tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] exp_q[$];
  int          out_src_q[$];
  int          out_beats = 0;
  logic [7:0]  s3_tid = '0;
  int          mdl_owner = -1;   // packet owner, -1 while arbitrating
  int          mdl_last  = N - 1;
  bit          mdl_valid = 1'b0;
  beat_t       mdl_b;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mdl_owner = -1;
        mdl_last  = N - 1;
        mdl_valid = 1'b0;
        exp_q.delete();
        acc = '0;
      end else begin
        logic [N-1:0] exp_rdy;
        int           cur;
        for (int s = 0; s < N; s++) begin
          acc[s] = cur_valid[s] && s_tready[s];
          if (acc[s]) exp_q.push_back(cur_b[s].data);
        end
        if (m_tvalid && m_tready) begin
          check_eq("sb_nonempty", 128'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check_eq("sb_data", m_tdata, exp_q.pop_front());
          out_beats++;
          if (m_tdata[31:24] == 8'd3) s3_tid = m_tid;
          if (m_tlast) out_src_q.push_back(int'(m_tdata[31:24]));
        end

        exp_rdy = '0;
        if (mdl_owner >= 0 && (!mdl_valid || m_tready)) exp_rdy[mdl_owner] = 1'b1;
        check_eq("grant", grant, (mdl_owner >= 0) ? 128'(1) << mdl_owner : 0);
        check_eq("busy", busy, 128'(mdl_owner >= 0));
        check_eq("s_tready", s_tready, exp_rdy);
        check_eq("m_tvalid", m_tvalid, 128'(mdl_valid));
        if (mdl_valid) begin
          check_eq("m_tdata", m_tdata, mdl_b.data);
          check_eq("m_tlast", m_tlast, mdl_b.last);
          check_eq("m_tid", m_tid, mdl_b.tid);
          check_eq("m_side", {m_tstrb, m_tkeep, m_tdest, m_tuser},
                   {mdl_b.strb, mdl_b.keep, mdl_b.dest, mdl_b.user});
        end

        cur = mdl_owner;
        if (cur >= 0 && cur_valid[cur] && (!mdl_valid || m_tready)) begin
          mdl_valid = 1'b1;
          mdl_b     = cur_b[cur];
`ifdef MIO_AXIS_ARB_SRC_TAG_EN
          mdl_b.tid = 8'(cur);
`endif
          if (cur_b[cur].last) begin
            mdl_last  = cur;
            mdl_owner = -1;
          end
        end else if (m_tready) begin
          mdl_valid = 1'b0;
        end
        if (cur < 0) begin
          for (int k = 1; k <= N; k++) begin
            if (mdl_owner < 0 && cur_valid[(mdl_last + k) % N]) mdl_owner = (mdl_last + k) % N;
          end
        end
      end
    end
  end

  // ---------------- wait helpers ----------------
  function automatic bit tb_idle();
    bit idle = (cur_valid == '0) && (mdl_owner < 0) && !mdl_valid;
    for (int s = 0; s < N; s++) if (pend_q[s].size() != 0) idle = 1'b0;
    return idle;
  endfunction

  task automatic wait_idle(input string tag, input int max);
    for (int c = 0; c < max && !tb_idle(); c++) @(posedge clk);
    repeat (2) @(posedge clk);
    #2;
    check_eq(tag, 128'(tb_idle()), 1);
  endtask

  task automatic wait_beats(input string tag, input int target, input int max);
    for (int c = 0; c < max && out_beats < target; c++) @(posedge clk);
    #2;
    check_eq(tag, 128'(out_beats >= target), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int    base, b0, total;
    beat_t b;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_m", {m_tvalid, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser}, 0);
    check_eq("rst_ctl", {grant, busy, s_tready}, 0);
    reset = 1'b0;
    @(posedge clk); #2;

    // all four sources request together: order 0,1,2,3 from reset priority
    base = out_src_q.size();
    for (int s = 0; s < N; s++) push_pkt(s, 2, 1, 0, 0, 0, -1);
    wait_idle("t_rr_idle", 200);
    for (int k = 0; k < N; k++) check_eq($sformatf("rr_order%0d", k),
                                         (out_src_q.size() > base + k) ? out_src_q[base + k] : -1, k);

    // single source 0, fixed payload 0x11..0x44
    b0 = out_beats;
    for (int k = 0; k < 4; k++) begin
      b = '0;
      b.data = 32'h11 * (k + 1);
      b.keep = 4'hf; b.strb = 4'hf;
      b.last = (k == 3);
      push_beat(0, b, 0);
    end
    wait_idle("t_single_idle", 200);
    check_eq("t_single_beats", out_beats - b0, 4);

    // master back-pressure for 5 cycles in the middle of a source 1 packet
    b0 = out_beats;
    push_pkt(1, 6, 2, 0, 0, 0, -1);
    wait_beats("t_bp_start", b0 + 1, 100);
    rdy_mode = 2;
    repeat (5) @(posedge clk);
    #2;
    rdy_mode = 0;
    wait_idle("t_bp_idle", 200);
    check_eq("t_bp_beats", out_beats - b0, 6);

    // source 2 pauses mid-packet while source 3 waits
    base = out_src_q.size();
    push_pkt(2, 5, 3, 0, 2, 3, -1);
    push_pkt(3, 2, 3, 2, 0, 0, -1);
    wait_idle("t_hold_idle", 200);
    check_eq("t_hold_first", (out_src_q.size() > base) ? out_src_q[base] : -1, 2);
    check_eq("t_hold_second", (out_src_q.size() > base + 1) ? out_src_q[base + 1] : -1, 3);

    // source tag on a single-beat packet from source 3
    push_pkt(3, 1, 4, 0, 0, 0, 8'hAB);
    wait_idle("t_tag_idle", 100);
`ifdef MIO_AXIS_ARB_SRC_TAG_EN
    check_eq("t_tag_tid", s3_tid, 8'h03);
`else
    check_eq("t_tag_tid", s3_tid, 8'hAB);
`endif

    // reset in the middle of a 5-beat packet, then 0 beats 1 on a simultaneous request
    b0 = out_beats;
    push_pkt(1, 5, 5, 0, 0, 0, -1);
    wait_beats("t_rst_start", b0 + 1, 100);
    reset = 1'b1;
    #1;
    check_eq("t_rst_m", {m_tvalid, m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser}, 0);
    check_eq("t_rst_ctl", {grant, busy, s_tready}, 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    base = out_src_q.size();
    push_pkt(0, 1, 6, 0, 0, 0, -1);
    push_pkt(1, 1, 6, 0, 0, 0, -1);
    wait_idle("t_rst_idle", 100);
    check_eq("t_rst_first", (out_src_q.size() > base) ? out_src_q[base] : -1, 0);
    check_eq("t_rst_second", (out_src_q.size() > base + 1) ? out_src_q[base + 1] : -1, 1);

    // random traffic with random back-pressure
    b0 = out_beats;
    total = 0;
    rdy_mode = 1;
    for (int p = 0; p < 80; p++) begin
      int s  = $urandom_range(0, N - 1);
      int nb = $urandom_range(1, 6);
      push_pkt(s, nb, 16 + p, $urandom_range(0, 4), $urandom_range(1, 5), $urandom_range(0, 3), -1);
      total += nb;
    end
    wait_idle("t_rand_idle", 20000);
    rdy_mode = 0;
    check_eq("t_rand_beats", out_beats - b0, total);
    check_eq("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
